// File: rtl/mux_lut_pkg.sv
// Shared types and helpers for the programmable mux LUT.
package mux_lut_pkg;

  // Configuration FSM: evaluate with the active table, or shift in a new one.
  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StLoad = 1'b1
  } state_e;

  // Reset truth table: OR of all operand bits (entry 0 low, every other entry high).
  // Returned at full 64-bit width; callers keep the low 2**n_in bits.
  function automatic logic [63:0] or_table(input int unsigned n_in);
    logic [63:0] tbl;
    tbl = '0;
    for (int unsigned i = 1; i < 64; i++) begin
      if (i < (64'd1 << n_in)) begin
        tbl[i] = 1'b1;
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/mux.sv
// Single-bit 2:1 multiplexer, the leaf cell of every lane selector tree.
module mux (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/programmable_mux_lut.sv
// Multi-lane programmable LUT: every lane looks up its operand in one shared
// truth table, which is reloaded serially while evaluation keeps running.
module programmable_mux_lut
  import mux_lut_pkg::*;
#(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [LANES*N_IN-1:0] in_data,
  output logic                  out_valid,
  output logic [LANES-1:0]      out_data,
  input  logic                  cfg_start,
  input  logic                  cfg_valid,
  input  logic                  cfg_bit,
  output logic                  cfg_busy,
  output logic                  cfg_done
);

  localparam int unsigned TBL_W = 1 << N_IN;
  // One extra bit so the count reaches TBL_W without wrapping.
  localparam int unsigned CNT_W = $clog2(TBL_W) + 1;

  localparam logic [TBL_W-1:0] OrTable = TBL_W'(or_table(N_IN));
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(TBL_W - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TBL_W-1:0]  shadow_q, shadow_d, shadow_wr;
  logic [TBL_W-1:0]  table_q, table_d;
  logic              done_q, done_d;

  logic                  s1_valid_q;
  logic [LANES*N_IN-1:0] s1_data_q;
  logic                  out_valid_q;
  logic [LANES-1:0]      out_data_q;
  logic [LANES-1:0]      lut_res;

  // Configuration state: FSM, bit counter, shadow and active tables, done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StRun;
      cnt_q    <= '0;
      shadow_q <= '0;
      table_q  <= OrTable;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      table_q  <= table_d;
      done_q   <= done_d;
    end
  end

  // Load sequencing; cfg_start outranks cfg_valid, and the last bit commits.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    table_d   = table_q;
    done_d    = 1'b0;
    shadow_wr = shadow_q;
    shadow_wr[cnt_q[CNT_W-2:0]] = cfg_bit;
    unique case (state_q)
      StRun: begin
        if (cfg_start) begin
          state_d  = StLoad;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      StLoad: begin
        if (cfg_start) begin
          cnt_d    = '0;
          shadow_d = '0;
        end else if (cfg_valid) begin
          shadow_d = shadow_wr;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LastIdx) begin
            // Commit includes the bit arriving this cycle.
            table_d = shadow_wr;
            state_d = StRun;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Stage 1: capture operands; data only moves on valid samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_data_q <= in_data;
      end
    end
  end

  // Per-lane selector: a binary tree of 2:1 cells, operand LSB at the leaves.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [N_IN-1:0] opnd;
    assign opnd = s1_data_q[k*N_IN +: N_IN];

    for (genvar l = 0; l < N_IN; l++) begin : g_lvl
      localparam int unsigned NumOut = TBL_W >> (l + 1);
      logic [2*NumOut-1:0] din;
      logic [NumOut-1:0]   dout;

      if (l == 0) begin : g_leaf
        assign din = table_q;
      end else begin : g_inner
        assign din = g_lvl[l-1].dout;
      end

      for (genvar m = 0; m < NumOut; m++) begin : g_mux
        mux u_mux (
          .d0  (din[2*m]),
          .d1  (din[2*m+1]),
          .sel (opnd[l]),
          .y   (dout[m])
        );
      end
    end

    assign lut_res[k] = g_lvl[N_IN-1].dout[0];
  end

  // Stage 2: register the lookup result; out_data holds between valid samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= lut_res;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cfg_busy  = (state_q == StLoad);
  assign cfg_done  = done_q;

endmodule

// File: doc/programmable_mux_lut.md
PROGRAMMABLE_MUX_LUT -- requirements
Module: programmable_mux_lut

Interface
REQ-001 SHALL have parameter N_IN, default 2, meaning inputs per lane (legal 1..6).
REQ-002 SHALL have parameter LANES, default 4, meaning independent lanes sharing one truth table.
REQ-003 SHALL have derived constant TBL_W = 2**N_IN, meaning truth-table width in bits.
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  marks in_data as valid this cycle.
REQ-007 SHALL have port in_data  input  LANES*N_IN  lane k operands at bits [k*N_IN +: N_IN].
REQ-008 SHALL have port out_valid  output  1  marks out_data as valid.
REQ-009 SHALL have port out_data  output  LANES  bit k is f(lane k operands).
REQ-010 SHALL have port cfg_start  input  1  one-cycle pulse that begins a table load.
REQ-011 SHALL have port cfg_valid  input  1  marks cfg_bit as valid.
REQ-012 SHALL have port cfg_bit  input  1  serial table bit, index 0 first.
REQ-013 SHALL have port cfg_busy  output  1  high while a load is in progress.
REQ-014 SHALL have port cfg_done  output  1  one-cycle pulse in the cycle after commit.

Function
REQ-015 SHALL evaluate out_data[k] = active_table[operand_k], where operand_k is used as an unsigned index.
REQ-016 SHALL use a 2-stage pipeline (stage 1 registers in_data/in_valid; stage 2 registers the mux-tree result), giving latency 2 cycles, throughput 1 per cycle, and no stall.
REQ-017 SHALL make out_valid equal to in_valid delayed 2 cycles, and SHALL hold out_data while out_valid is low.
REQ-018 SHALL implement FSM states RUN and LOAD, with reset state RUN.
REQ-019 SHALL transition RUN -> LOAD on cfg_start, clearing the bit counter and shadow table.
REQ-020 SHALL, in LOAD, shift each cfg_bit into shadow[counter] when cfg_valid is high and increment the counter; cycles with cfg_valid low are ignored.
REQ-021 SHALL, on the TBL_W-th accepted bit, copy the shadow table to active_table atomically at that edge, go to RUN, and pulse cfg_done in the next cycle.
REQ-022 SHALL restart the load on cfg_start while in LOAD (counter to 0, partial shadow discarded, state remains LOAD).
REQ-023 SHALL give cfg_start priority over cfg_valid when both are high in the same cycle: restart, and the bit is not stored.
REQ-024 SHALL ignore cfg_valid while in RUN.
REQ-025 SHALL keep evaluation running during LOAD using the old active_table.
REQ-026 SHALL evaluate a stage-1 sample with the active_table present at the stage-2 capture edge; a commit on that same edge is not visible until the following edge.
REQ-027 SHALL drive cfg_busy = (state == LOAD).
REQ-028 SHALL size the counter to $clog2(TBL_W)+1 bits so it cannot wrap before commit.

Reset
REQ-029 SHALL, on rst, force state RUN, counter 0, shadow 0, out_valid 0, out_data 0, cfg_done 0, cfg_busy 0, and clear the pipeline valids.
REQ-030 SHALL reset active_table to the OR function: bit 0 = 0, all other bits = 1.
REQ-031 SHALL abort any load in progress on rst mid-load, leaving active_table at the OR table.

Structure
REQ-032 SHALL place the FSM state enum and the function or_table(N_IN) that returns the reset table in the shared package mux_lut_pkg.
REQ-033 SHALL build each lane's selector as a tree of instances of the existing 2:1 sub-module mux (TBL_W-1 instances per lane, generate loops), with no behavioural index operator.

Verification
REQ-034 SHALL cover: reset, then operands 00,01,10,11 on lane 0 -> out_data[0] = 0,1,1,1, each 2 cycles after its input.
REQ-035 SHALL cover: cfg_start, then bits 0,0,0,1 (AND table) -> cfg_done pulses once; operands 11/10 -> 1/0.
REQ-036 SHALL cover: operand 01 applied every cycle during that load -> 1 until the commit edge per REQ-026, then 0.
REQ-037 SHALL cover: bits 1,1 then cfg_start, then 0,1,1,0 -> XOR table active, with 2 partial bits discarded.
REQ-038 SHALL cover: rst asserted after 3 of 4 bits -> cfg_busy 0, OR table active, no cfg_done.
REQ-039 SHALL cover: with N_IN=3 and LANES=2, back-to-back random operands for 100 cycles -> match the reference model with zero bubbles.
